// File: rtl/hdmi_tx_if.sv
// Video bus between the raster generator, the renderer and the HDMI pins.
// master: the raster/pixel stage (drives coordinates and pins).
// slave:  the renderer/board side (drives colour and the blank request).
interface hdmi_tx_if;
  logic [11:0] x;
  logic [11:0] y;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        force_blank;
  logic        hdmi_clk;
  logic [23:0] hdmi_d;
  logic        hdmi_de;
  logic        hdmi_hs;
  logic        hdmi_vs;

  modport master (
    output x, y, hdmi_clk, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs,
    input  r, g, b, force_blank
  );

  modport slave (
    input  x, y, hdmi_clk, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs,
    output r, g, b, force_blank
  );
endinterface

// File: rtl/hdmi_tx.sv
// Raster timing generator and registered pixel output stage (640x480@60 by default).
// Counters run active-first: active, front porch, sync, back porch.
// x/y are combinational from the counters; pins are one register stage later.
// Optional feature macro: PIXEL_DOUBLE_EN (x/y halved for a 2x scaled image).
// resetn is active-high despite its name and acts asynchronously.
module hdmi_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       resetn,
  hdmi_tx_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_MAX     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_MAX     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [23:0] hdmi_d_q, hdmi_d_d;
  logic        hdmi_de_q, hdmi_de_d;
  logic        hdmi_hs_q, hdmi_hs_d;
  logic        hdmi_vs_q, hdmi_vs_d;
  logic        active, hsync, vsync;

  // Next raster position: hcnt wraps at end of line, vcnt steps on that wrap.
  always_comb begin
    hcnt_d = hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_MAX) begin
      hcnt_d = 12'd0;
      vcnt_d = (vcnt_q == V_MAX) ? 12'd0 : vcnt_q + 12'd1;
    end
  end

  // Region decode and the values the pin register loads this cycle.
  always_comb begin
    active    = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
    hsync     = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    vsync     = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    hdmi_d_d  = (active && !vid.force_blank) ? {vid.r, vid.g, vid.b} : 24'h0;
    hdmi_de_d = active;
    hdmi_hs_d = !hsync;
    hdmi_vs_d = !vsync;
  end

  // Counters and the single output stage shared by d/de/hs/vs.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      hcnt_q    <= 12'd0;
      vcnt_q    <= 12'd0;
      hdmi_d_q  <= 24'h0;
      hdmi_de_q <= 1'b0;
      hdmi_hs_q <= 1'b1;
      hdmi_vs_q <= 1'b1;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hdmi_d_q  <= hdmi_d_d;
      hdmi_de_q <= hdmi_de_d;
      hdmi_hs_q <= hdmi_hs_d;
      hdmi_vs_q <= hdmi_vs_d;
    end
  end

`ifdef PIXEL_DOUBLE_EN
  // Each logical pixel covers a 2x2 block of raster positions.
  assign vid.x = {1'b0, hcnt_q[11:1]};
  assign vid.y = {1'b0, vcnt_q[11:1]};
`else
  assign vid.x = hcnt_q;
  assign vid.y = vcnt_q;
`endif

  // Inverted clock puts the transmitter's latch edge mid-way through the data eye.
  assign vid.hdmi_clk = ~clk;
  assign vid.hdmi_d   = hdmi_d_q;
  assign vid.hdmi_de  = hdmi_de_q;
  assign vid.hdmi_hs  = hdmi_hs_q;
  assign vid.hdmi_vs  = hdmi_vs_q;

endmodule

// File: tb/tb_hdmi_tx.sv
// Bench for hdmi_tx: a full-size 640x480 instance for line-level behaviour and a
// small-raster instance so whole frames (vsync, frame repeat) fit in a short run.
module tb_hdmi_tx;
  logic clk = 1'b0;
  logic resetn;
  logic fb;
  int   cyc;
  logic last_fb;
  int   total = 0;
  int   bad = 0;

  hdmi_tx_if vif_a ();
  hdmi_tx_if vif_b ();

  hdmi_tx dut_a (.clk(clk), .resetn(resetn), .vid(vif_a));

  hdmi_tx #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (.clk(clk), .resetn(resetn), .vid(vif_b));

  // Renderer: r = x, g = y, b = A5, combinational from the presented coordinate.
  assign vif_a.r = vif_a.x[7:0];
  assign vif_a.g = vif_a.y[7:0];
  assign vif_a.b = 8'hA5;
  assign vif_a.force_blank = fb;
  assign vif_b.r = vif_b.x[7:0];
  assign vif_b.g = vif_b.y[7:0];
  assign vif_b.b = 8'hA5;
  assign vif_b.force_blank = fb;

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or posedge resetn) begin
    if (resetn) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d t=%0t", nm, act, exp, cyc, $time);
    end
  endtask

  // Model: position is pure arithmetic on the edge count; outputs describe pixel k-1.
  task automatic check_pix(input string nm, input int k,
                           input int ha, input int hf, input int hsw, input int hb,
                           input int va, input int vf, input int vsw, input int vb,
                           input logic [11:0] ax, input logic [11:0] ay,
                           input logic [23:0] ad, input logic ade,
                           input logic ahs, input logic avs, input logic fbp);
    int ht, vt, hc, vc, p, hp, vp, lx, ly;
    logic act_e;
    logic [23:0] d_e;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    hc = k % ht;
    vc = (k / ht) % vt;
`ifdef PIXEL_DOUBLE_EN
    chk({nm, "_x"}, 32'(ax), 32'(hc / 2));
    chk({nm, "_y"}, 32'(ay), 32'(vc / 2));
`else
    chk({nm, "_x"}, 32'(ax), 32'(hc));
    chk({nm, "_y"}, 32'(ay), 32'(vc));
`endif
    if (k == 0) begin
      chk({nm, "_d"},  32'(ad),  32'h0);
      chk({nm, "_de"}, 32'(ade), 32'h0);
      chk({nm, "_hs"}, 32'(ahs), 32'h1);
      chk({nm, "_vs"}, 32'(avs), 32'h1);
    end else begin
      p  = k - 1;
      hp = p % ht;
      vp = (p / ht) % vt;
`ifdef PIXEL_DOUBLE_EN
      lx = hp / 2;
      ly = vp / 2;
`else
      lx = hp;
      ly = vp;
`endif
      act_e = (hp < ha) && (vp < va);
      d_e = (act_e && !fbp) ? {lx[7:0], ly[7:0], 8'hA5} : 24'h0;
      chk({nm, "_d"},  32'(ad),  32'(d_e));
      chk({nm, "_de"}, 32'(ade), 32'(act_e));
      chk({nm, "_hs"}, 32'(ahs), 32'(!((hp >= ha + hf) && (hp < ha + hf + hsw))));
      chk({nm, "_vs"}, 32'(avs), 32'(!((vp >= va + vf) && (vp < va + vf + vsw))));
    end
  endtask

  // Single compare process on the falling edge, plus literal pins of the model.
  always @(negedge clk) begin
    if (resetn !== 1'bx) begin
      chk("hdmi_clk_a", 32'(vif_a.hdmi_clk), 32'h1);
      check_pix("a", cyc, 640, 16, 96, 48, 480, 10, 2, 33,
                vif_a.x, vif_a.y, vif_a.hdmi_d, vif_a.hdmi_de,
                vif_a.hdmi_hs, vif_a.hdmi_vs, last_fb);
      check_pix("b", cyc, 16, 4, 6, 4, 8, 2, 2, 3,
                vif_b.x, vif_b.y, vif_b.hdmi_d, vif_b.hdmi_de,
                vif_b.hdmi_hs, vif_b.hdmi_vs, last_fb);
      if (!resetn) begin
        if (cyc == 1)    chk("lit_de_first",    32'(vif_a.hdmi_de), 32'h1);
        if (cyc == 640)  chk("lit_de_last",     32'(vif_a.hdmi_de), 32'h1);
        if (cyc == 641)  chk("lit_de_off",      32'(vif_a.hdmi_de), 32'h0);
        if (cyc == 801)  chk("lit_de_line1",    32'(vif_a.hdmi_de), 32'h1);
        if (cyc == 656)  chk("lit_hs_pre",      32'(vif_a.hdmi_hs), 32'h1);
        if (cyc == 657)  chk("lit_hs_first",    32'(vif_a.hdmi_hs), 32'h0);
        if (cyc == 752)  chk("lit_hs_last",     32'(vif_a.hdmi_hs), 32'h0);
        if (cyc == 753)  chk("lit_hs_post",     32'(vif_a.hdmi_hs), 32'h1);
        if (cyc == 641)  chk("lit_blank_d",     32'(vif_a.hdmi_d),  32'h0);
`ifdef PIXEL_DOUBLE_EN
        if (cyc == 5701) chk("lit_pix_100_7",   32'(vif_a.hdmi_d),  32'h3203A5);
        if (cyc == 640)  chk("lit_x_max",       32'(vif_a.x),       32'd320);
`else
        if (cyc == 5701) chk("lit_pix_100_7",   32'(vif_a.hdmi_d),  32'h6407A5);
`endif
        if (cyc == 5701) chk("lit_pix_de",      32'(vif_a.hdmi_de), 32'h1);
        if (cyc == 1730) chk("lit_fb_d",        32'(vif_a.hdmi_d),  32'h0);
        if (cyc == 1730) chk("lit_fb_de",       32'(vif_a.hdmi_de), 32'h1);
        if (cyc == 300)  chk("lit_vs_pre",      32'(vif_b.hdmi_vs), 32'h1);
        if (cyc == 301)  chk("lit_vs_first",    32'(vif_b.hdmi_vs), 32'h0);
        if (cyc == 360)  chk("lit_vs_last",     32'(vif_b.hdmi_vs), 32'h0);
        if (cyc == 361)  chk("lit_vs_post",     32'(vif_b.hdmi_vs), 32'h1);
        if (cyc == 751)  chk("lit_vs_frame2",   32'(vif_b.hdmi_vs), 32'h0);
        if (cyc == 450)  chk("lit_frame_end",   32'(vif_b.hdmi_de), 32'h0);
        if (cyc == 451)  chk("lit_frame_rep_de", 32'(vif_b.hdmi_de), 32'h1);
        if (cyc == 451)  chk("lit_frame_rep_d", 32'(vif_b.hdmi_d),  32'h0000A5);
      end
    end
    last_fb = fb;
  end

  initial begin
    resetn  = 1'b1;
    fb      = 1'b0;
    last_fb = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #2;
    end
    // Mid-line reset: outputs must clear at once, without waiting for a clock.
    resetn = 1'b1;
    #1;
    chk("rst_x",    32'(vif_a.x),        32'h0);
    chk("rst_y",    32'(vif_a.y),        32'h0);
    chk("rst_de",   32'(vif_a.hdmi_de),  32'h0);
    chk("rst_hs",   32'(vif_a.hdmi_hs),  32'h1);
    chk("rst_vs",   32'(vif_a.hdmi_vs),  32'h1);
    chk("rst_d",    32'(vif_a.hdmi_d),   32'h0);
    chk("rst_hclk", 32'(vif_a.hdmi_clk), 32'h0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #2;
      fb = (cyc >= 1700) && (cyc < 1760);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdmi_tx.md
# hdmi_tx

- Raster timing generator and pixel output stage for the HDMI transmitter chip.
- Produces a 640x480@60 scan:
  - runs the horizontal and vertical counters;
  - exports the current pixel coordinate to the picture logic;
  - samples the combinational RGB answer;
  - drives registered 24-bit parallel data, data-enable and sync pins, plus a pixel clock aligned for the transmitter's input latch.
- Sits between the tile/palette renderer and the board-level HDMI pins, clocked by the divided video clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- clk  in  1  pixel clock; all logic on the rising edge
- resetn  in  1  asynchronous reset, active-high (asserted at 1)
- x  out  12  current pixel column for the renderer
- y  out  12  current pixel row for the renderer
- r, g, b  in  8 each  renderer colour for (x, y), combinational, same cycle
- hdmi_clk  out  1  transmitter pixel clock = ~clk
- hdmi_d  out  24  pixel data {r, g, b}
- hdmi_de  out  1  data enable
- hdmi_hs  out  1  horizontal sync, active-low
- force_blank  in  1  1 forces hdmi_d to 0; timing is unaffected
- hdmi_vs  out  1  vertical sync, active-low

## Operation
- hcnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800).
  - hcnt wraps to 0 and vcnt increments on the cycle hcnt = H_TOTAL-1.
  - vcnt runs 0..V_TOTAL-1 (525) and wraps to 0 when both counters are at their maxima.
- Order is active-first:
  - active when hcnt < H_ACTIVE and vcnt < V_ACTIVE;
  - hsync when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751);
  - vsync when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- x = hcnt and y = vcnt, zero-extended to 12 bits.
  - Combinational from the counters, valid for the whole cycle.
  - Outside the active region they keep counting; the renderer's output there is ignored.
- Output register, loaded every clk:
  - hdmi_d <= (active && !force_blank) ? {r, g, b} : 24'h0;
  - hdmi_de <= active;
  - hdmi_hs <= !hsync;
  - hdmi_vs <= !vsync.
- hdmi_clk = ~clk: the rising edge of hdmi_clk falls mid-cycle, centred in the data eye.

## Timing
- Reset (asynchronous, while resetn = 1):
  - hcnt = vcnt = 0, so x = y = 0;
  - hdmi_d = 0, hdmi_de = 0;
  - hdmi_hs = 1, hdmi_vs = 1.
  - hdmi_clk keeps toggling.
- After release, the first rising edge registers pixel (0,0). Output latency is exactly 1 clk from the x/y presentation.
- de, hs, vs and d share the same single register stage and stay mutually aligned.
- Frame = 800 x 525 = 420000 clk. Per line, de is high for 640 consecutive cycles and hs is low for 96.
- A reset asserted mid-frame restarts the frame at (0,0) with no partial-line artefacts beyond the reset instant.
- force_blank is sampled per pixel, with the same 1-clk latency as r/g/b.

## Configuration
- PIXEL_DOUBLE_EN defined:
  - x = hcnt >> 1 and y = vcnt >> 1, a 320x240 logical image scaled 2x;
  - each renderer pixel appears for 2 clk on 2 lines;
  - sync and de timing are unchanged.
- Undefined: x = hcnt and y = vcnt (native 640x480).

## Test plan
- Assert resetn=1 mid-line -> immediately x=0, y=0, hdmi_de=0, hdmi_hs=1, hdmi_vs=1, hdmi_d=0.
- Release reset and count cycles:
  - hdmi_de first high 1 clk after release;
  - de high 640 clk, low 160 per line;
  - hdmi_hs low exactly during clks 657..752 after the line start.
- Full frame: hdmi_vs low for exactly 2 lines (1600 clk), starting on line 490; the frame repeats every 420000 clk.
- Renderer model r=x[7:0], g=y[7:0], b=8'hA5: at x=100, y=7 -> next cycle hdmi_d=24'h6407A5 with hdmi_de=1; during blanking hdmi_d=0.
- force_blank=1 during an active line -> hdmi_d=0 while hdmi_de stays 1; hs/vs unchanged.
- With PIXEL_DOUBLE_EN:
  - x sequence 0,0,1,1,...,319,319 on each line;
  - y constant across line pairs;
  - max x=319 and max y=239 in the active area.
